// File: rtl/e203_ifu_pkg.sv
// ---------------------------------------------------------------------------
// e203_ifu_pkg
// Shared definitions for the IFU flush controller slice:
//   - flush FSM state encoding (IDLE / DRAIN / REDIR)
//   - default PC bus width
// Optional feature macro used by the importing top: E203_FLUSH_PC_BYPASS_EN
// ---------------------------------------------------------------------------
package e203_ifu_pkg;

    localparam int PC_SIZE_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

endpackage

// File: rtl/e203_ifu_outs_cnt.sv
// ---------------------------------------------------------------------------
// e203_ifu_outs_cnt
// Saturating up/down counter of outstanding ifetch bus requests.
// Ports:
//   clk, rst   core clock, synchronous active-high reset
//   inc        request handshake this cycle (+1)
//   dec        response handshake this cycle (-1)
//   cnt        current outstanding count
//   full       cnt == OUTS_MAX
//   empty      cnt == 0
// Simultaneous inc and dec leave the count unchanged; inc at full and
// dec at empty are ignored so the count stays within [0, OUTS_MAX].
// ---------------------------------------------------------------------------
module e203_ifu_outs_cnt #(
    parameter int OUTS_MAX = 2,
    parameter int CNT_W    = $clog2(OUTS_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTS_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full  = (cnt_q == CNT_MAX);
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/e203_ifu_flush_ctrl.sv
// ---------------------------------------------------------------------------
// e203_ifu_flush_ctrl
// Consumes the commit-stage flush request, computes the redirect PC, drains
// or kills in-flight instruction fetches, acknowledges the flush only once no
// pre-flush fetch is outstanding, then presents one redirect to the fetch FSM.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   pipe_flush_req/ack  flush handshake with commit (ack is combinational)
//   pipe_flush_add_op1/2 flush PC adder operands
//   pipe_flush_pc       precomputed flush PC (only with E203_FLUSH_PC_BYPASS_EN)
//   ifetch_req_hsk      ifetch bus request accepted this cycle
//   ifetch_rsp_hsk      ifetch bus response returned this cycle
//   ifetch_req_allow    fetch FSM may issue a new bus request
//   ifetch_rsp_drop     current response is stale and must be discarded
//   redir_valid/ready   redirect handshake with the fetch FSM
//   redir_pc            redirect target
//   flush_busy          controller not idle
//
// Configuration macro: E203_FLUSH_PC_BYPASS_EN
//   defined   -> pipe_flush_pc is latched directly, the adder is removed and
//                the operand ports remain but are ignored
//   undefined -> flush PC is op1 + op2 (carry discarded)
// In both builds the target is halfword aligned (bit 0 cleared).
// ---------------------------------------------------------------------------
module e203_ifu_flush_ctrl
    import e203_ifu_pkg::*;
#(
    parameter int PC_SIZE  = PC_SIZE_DEF,
    parameter int OUTS_MAX = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_flush_req,
    output logic               pipe_flush_ack,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
`ifdef E203_FLUSH_PC_BYPASS_EN
    input  logic [PC_SIZE-1:0] pipe_flush_pc,
`endif
    input  logic               ifetch_req_hsk,
    input  logic               ifetch_rsp_hsk,
    output logic               ifetch_req_allow,
    output logic               ifetch_rsp_drop,
    output logic               redir_valid,
    input  logic               redir_ready,
    output logic [PC_SIZE-1:0] redir_pc,
    output logic               flush_busy
);

    localparam int CNT_W = $clog2(OUTS_MAX + 1);

    function automatic logic [PC_SIZE-1:0] align_pc(input logic [PC_SIZE-1:0] pc);
        return pc & ~PC_SIZE'(1);
    endfunction

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [PC_SIZE-1:0] redir_pc_q;
    logic [PC_SIZE-1:0] redir_pc_d;
    logic               drop_q;
    logic               drop_d;

    logic [CNT_W-1:0]   outs_cnt;
    logic               outs_full;
    logic               outs_empty;
    logic               last_rsp;
    logic               cnt_zero_nxt;
    logic               drain_start;
    logic               ack_int;
    logic [PC_SIZE-1:0] flush_pc;

    e203_ifu_outs_cnt #(
        .OUTS_MAX (OUTS_MAX),
        .CNT_W    (CNT_W)
    ) u_outs_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifetch_req_hsk),
        .dec   (ifetch_rsp_hsk),
        .cnt   (outs_cnt),
        .full  (outs_full),
        .empty (outs_empty)
    );

`ifdef E203_FLUSH_PC_BYPASS_EN
    assign flush_pc = align_pc(pipe_flush_pc);
`else
    assign flush_pc = align_pc(pipe_flush_add_op1 + pipe_flush_add_op2);
`endif

    // The final outstanding response is returning alone this cycle, so the
    // count reaches zero at the next edge and the flush may be acked now.
    assign last_rsp     = (outs_cnt == CNT_W'(1)) && ifetch_rsp_hsk && !ifetch_req_hsk;
    assign cnt_zero_nxt = (outs_empty && !ifetch_req_hsk) || last_rsp;
    assign drain_start  = (state_q == ST_IDLE) && pipe_flush_req && !outs_empty;

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        ack_int    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pipe_flush_req) begin
                    if (outs_empty) begin
                        ack_int = 1'b1;
                        state_d = ST_REDIR;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!pipe_flush_req) begin
                    // Flush withdrawn; drop_q keeps killing stale responses.
                    state_d = ST_IDLE;
                end else if (outs_empty || last_rsp) begin
                    ack_int = 1'b1;
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                // A newer flush overrides the pending redirect even when the
                // fetch FSM is taking it in the same cycle.
                if (pipe_flush_req && outs_empty) begin
                    ack_int = 1'b1;
                end else if (pipe_flush_req) begin
                    state_d = ST_DRAIN;
                end else if (redir_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ack_int) begin
            redir_pc_d = flush_pc;
        end
    end

    // Stale-response marker: armed when a flush must wait for fetches,
    // released as soon as nothing issued before the flush remains in flight.
    always_comb begin
        drop_d = (drop_q || drain_start || (state_q == ST_DRAIN)) && !cnt_zero_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            redir_pc_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            drop_q     <= drop_d;
        end
    end

    // All outputs are forced low while reset is held.
    assign pipe_flush_ack   = !rst && ack_int;
    assign ifetch_req_allow = !rst && (state_q == ST_IDLE) && !pipe_flush_req && !outs_full;
    assign ifetch_rsp_drop  = !rst && ifetch_rsp_hsk &&
                              (drop_q || drain_start || (state_q == ST_DRAIN));
    assign redir_valid      = !rst && (state_q == ST_REDIR);
    assign redir_pc         = rst ? '0 : redir_pc_q;
    assign flush_busy       = !rst && (state_q != ST_IDLE);

endmodule
